// File: rtl/ctrl_relu_wb_seq.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_relu_wb_seq
// Purpose  : Writeback sequencer for the ReLU output stage. On an accepted
//            start it walks up to MAX_LANES accumulator lanes. For each lane
//            it drives the ReLU output-mux select and a write request with
//            address to the output memory, stalling on back-pressure.
// Ports    : clk, rst_n              - clock, async active-low reset
//            start, abort            - control from the main FSM
//            num_lanes, base_addr    - job parameters, sampled on start
//            wr_ready                - output memory accept
//            sel_mux_relu            - ReLU mux select (current lane)
//            wr_valid, wr_addr       - output memory write request
//            busy, done              - status back to the main FSM
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_relu_wb_seq #(
    parameter int ADDR_W    = 8,
    parameter int MAX_LANES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [2:0]        num_lanes,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              wr_ready,
    output logic [1:0]        sel_mux_relu,
    output logic              wr_valid,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] C_MAX_LANES = 3'(MAX_LANES);

    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_LOAD  = 2'd1;
    localparam logic [1:0] C_ST_WRITE = 2'd2;
    localparam logic [1:0] C_ST_DONE  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [1:0]        lane_q,  lane_d;
    logic [2:0]        count_q, count_d;
    logic [ADDR_W-1:0] base_q,  base_d;

    // Current lane is the final one of this job. Only consulted in WRITE,
    // where count_q is known to be non-zero, so the subtraction never wraps.
    logic w_last_lane;
    assign w_last_lane = ({1'b0, lane_q} == (count_q - 3'd1));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= C_ST_IDLE;
            lane_q  <= 2'd0;
            count_q <= 3'd0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            count_q <= count_d;
            base_q  <= base_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        count_d = count_q;
        base_d  = base_q;

        // Abort outranks everything, including a start seen in IDLE.
        if (abort) begin
            state_d = C_ST_IDLE;
            lane_d  = 2'd0;
        end else begin
            case (state_q)
                C_ST_IDLE: begin
                    if (start) begin
                        count_d = (num_lanes > C_MAX_LANES) ? C_MAX_LANES : num_lanes;
                        base_d  = base_addr;
                        lane_d  = 2'd0;
                        state_d = C_ST_LOAD;
                    end
                end
                C_ST_LOAD: begin
                    state_d = (count_q == 3'd0) ? C_ST_DONE : C_ST_WRITE;
                end
                C_ST_WRITE: begin
                    // Without wr_ready everything holds, so the request stays
                    // stable for as long as the memory stalls.
                    if (wr_ready) begin
                        if (w_last_lane) begin
                            state_d = C_ST_DONE;
                        end else begin
                            lane_d = lane_q + 2'd1;
                        end
                    end
                end
                C_ST_DONE: begin
                    state_d = C_ST_IDLE;
                end
                default: begin
                    state_d = C_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Output decode: Moore, from registered state only
    // ------------------------------------------------------------------
    always_comb begin
        sel_mux_relu = 2'd0;
        wr_valid     = 1'b0;
        wr_addr      = '0;
        busy         = 1'b0;
        done         = 1'b0;

        case (state_q)
            C_ST_LOAD: begin
                busy = 1'b1;
            end
            C_ST_WRITE: begin
                busy         = 1'b1;
                wr_valid     = 1'b1;
                sel_mux_relu = lane_q;
                // Natural truncation gives the modulo-2^ADDR_W wrap.
                wr_addr      = base_q + ADDR_W'(lane_q);
            end
            C_ST_DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_ctrl_relu_wb_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_relu_wb_seq
// Purpose  : Self-checking bench for ctrl_relu_wb_seq: a table of per-cycle
//            vectors, hand-written multi-cycle corner sequences, and a
//            randomized run checked against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_relu_wb_seq;

    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [2:0]    num_lanes = 3'd0;
    logic [AW-1:0] base_addr = '0;
    logic          wr_ready = 1'b0;
    logic [1:0]    sel_mux_relu;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic          busy;
    logic          done;

    int n_total = 0;
    int n_bad   = 0;

    ctrl_relu_wb_seq #(.ADDR_W(AW), .MAX_LANES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .num_lanes    (num_lanes),
        .base_addr    (base_addr),
        .wr_ready     (wr_ready),
        .sel_mux_relu (sel_mux_relu),
        .wr_valid     (wr_valid),
        .wr_addr      (wr_addr),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          st;
        logic          ab;
        logic [2:0]    n;
        logic [AW-1:0] b;
        logic          rdy;
        logic [1:0]    sel;
        logic          v;
        logic [AW-1:0] a;
        logic          bz;
        logic          d;
    } vec_t;

    typedef struct {
        logic [1:0]    sel;
        logic [AW-1:0] addr;
    } wr_t;

    vec_t tbl[$];

    // Reference model state: a job is a list of pending writes.
    bit  m_active = 1'b0;
    bit  m_load   = 1'b0;
    wr_t m_q[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic s, input logic a, input logic [2:0] n,
                         input logic [AW-1:0] b, input logic r);
        start     = s;
        abort     = a;
        num_lanes = n;
        base_addr = b;
        wr_ready  = r;
    endtask

    task automatic chk(input string name, input logic [1:0] e_sel, input logic e_v,
                       input logic [AW-1:0] e_a, input logic e_b, input logic e_d);
        logic [AW+4:0] act;
        logic [AW+4:0] exp;
        act = {sel_mux_relu, wr_valid, wr_addr, busy, done};
        exp = {e_sel, e_v, e_a, e_b, e_d};
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got sel=%0d valid=%0b addr=%02h busy=%0b done=%0b, want sel=%0d valid=%0b addr=%02h busy=%0b done=%0b",
                     name, sel_mux_relu, wr_valid, wr_addr, busy, done,
                     e_sel, e_v, e_a, e_b, e_d);
        end
    endtask

    task automatic row(input logic st, input logic ab, input logic [2:0] n,
                       input logic [AW-1:0] b, input logic rdy, input logic [1:0] sel,
                       input logic v, input logic [AW-1:0] a, input logic bz, input logic d);
        vec_t r;
        r.st = st; r.ab = ab; r.n = n; r.b = b; r.rdy = rdy;
        r.sel = sel; r.v = v; r.a = a; r.bz = bz; r.d = d;
        tbl.push_back(r);
    endtask

    initial begin
        int acc;

        // ---------------- reset ----------------
        #12;
        chk("reset_hold", 2'd0, 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("reset_idle", 2'd0, 1'b0, 8'h00, 1'b0, 1'b0);

        // ---------------- table: inputs for one cycle, outputs after the edge
        // 4 lanes from 0x10, no back-pressure
        row(1, 0, 3'd4, 8'h10, 1, 2'd0, 0, 8'h00, 1, 0);  // LOAD
        row(0, 0, 3'd0, 8'h00, 1, 2'd0, 1, 8'h10, 1, 0);
        row(0, 0, 3'd0, 8'h00, 1, 2'd1, 1, 8'h11, 1, 0);
        row(0, 0, 3'd0, 8'h00, 1, 2'd2, 1, 8'h12, 1, 0);
        row(0, 0, 3'd0, 8'h00, 1, 2'd3, 1, 8'h13, 1, 0);
        row(0, 0, 3'd0, 8'h00, 1, 2'd0, 0, 8'h00, 1, 1);  // DONE
        row(0, 0, 3'd0, 8'h00, 1, 2'd0, 0, 8'h00, 0, 0);  // IDLE
        // zero lanes: no writes, done in cycle 2
        row(1, 0, 3'd0, 8'h33, 1, 2'd0, 0, 8'h00, 1, 0);
        row(0, 0, 3'd0, 8'h00, 1, 2'd0, 0, 8'h00, 1, 1);
        row(0, 0, 3'd0, 8'h00, 1, 2'd0, 0, 8'h00, 0, 0);
        // 6 lanes clamps to 4, base 0xFE wraps; started straight after done
        row(1, 0, 3'd6, 8'hFE, 1, 2'd0, 0, 8'h00, 1, 0);
        row(0, 0, 3'd0, 8'h00, 1, 2'd0, 1, 8'hFE, 1, 0);
        row(0, 0, 3'd0, 8'h00, 1, 2'd1, 1, 8'hFF, 1, 0);
        row(0, 0, 3'd0, 8'h00, 1, 2'd2, 1, 8'h00, 1, 0);
        row(0, 0, 3'd0, 8'h00, 1, 2'd3, 1, 8'h01, 1, 0);
        row(0, 0, 3'd0, 8'h00, 1, 2'd0, 0, 8'h00, 1, 1);
        row(0, 0, 3'd0, 8'h00, 1, 2'd0, 0, 8'h00, 0, 0);
        // start and abort together in IDLE: abort wins
        row(1, 1, 3'd2, 8'h44, 1, 2'd0, 0, 8'h00, 0, 0);
        row(0, 0, 3'd0, 8'h00, 1, 2'd0, 0, 8'h00, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].st, tbl[i].ab, tbl[i].n, tbl[i].b, tbl[i].rdy);
            step();
            chk($sformatf("vec%0d", i), tbl[i].sel, tbl[i].v, tbl[i].a, tbl[i].bz, tbl[i].d);
        end

        // ---------------- stall: 3 lanes, wr_ready low in cycles 3..5
        acc = 0;
        for (int c = 0; c <= 8; c++) begin
            drive(c == 0, 1'b0, 3'd3, 8'h40, !(c >= 3 && c <= 5));
            if (wr_valid && wr_ready) acc++;
            step();
            case (c + 1)
                1:             chk("stall_load", 2'd0, 0, 8'h00, 1, 0);
                2:             chk("stall_w0",   2'd0, 1, 8'h40, 1, 0);
                3, 4, 5, 6:    chk("stall_w1",   2'd1, 1, 8'h41, 1, 0);
                7:             chk("stall_w2",   2'd2, 1, 8'h42, 1, 0);
                8:             chk("stall_done", 2'd0, 0, 8'h00, 1, 1);
                default:       chk("stall_idle", 2'd0, 0, 8'h00, 0, 0);
            endcase
        end
        n_total++;
        if (acc != 3) begin
            n_bad++;
            $display("FAIL stall_writes: got %0d accepted writes, want 3", acc);
        end

        // ---------------- abort during the 2nd write, then clean rerun
        drive(1, 0, 3'd4, 8'h20, 1); step(); chk("ab_load", 2'd0, 0, 8'h00, 1, 0);
        drive(0, 0, 3'd0, 8'h00, 1); step(); chk("ab_w0",   2'd0, 1, 8'h20, 1, 0);
        step();                             chk("ab_w1",   2'd1, 1, 8'h21, 1, 0);
        drive(0, 1, 3'd0, 8'h00, 1); step(); chk("ab_idle", 2'd0, 0, 8'h00, 0, 0);
        drive(0, 0, 3'd0, 8'h00, 1); step(); chk("ab_nodone", 2'd0, 0, 8'h00, 0, 0);
        drive(1, 0, 3'd2, 8'h50, 1); step(); chk("re_load", 2'd0, 0, 8'h00, 1, 0);
        drive(0, 0, 3'd0, 8'h00, 1); step(); chk("re_w0",   2'd0, 1, 8'h50, 1, 0);
        step();                             chk("re_w1",   2'd1, 1, 8'h51, 1, 0);
        step();                             chk("re_done", 2'd0, 0, 8'h00, 1, 1);
        step();                             chk("re_idle", 2'd0, 0, 8'h00, 0, 0);

        // ---------------- start while busy is ignored
        drive(1, 0, 3'd2, 8'h60, 1); step(); chk("sb_load", 2'd0, 0, 8'h00, 1, 0);
        drive(1, 0, 3'd4, 8'h00, 1); step(); chk("sb_w0",   2'd0, 1, 8'h60, 1, 0);
        drive(1, 0, 3'd4, 8'h00, 0); step(); chk("sb_hold", 2'd0, 1, 8'h60, 1, 0);
        drive(0, 0, 3'd0, 8'h00, 1); step(); chk("sb_w1",   2'd1, 1, 8'h61, 1, 0);
        step();                             chk("sb_done", 2'd0, 0, 8'h00, 1, 1);
        step();                             chk("sb_idle", 2'd0, 0, 8'h00, 0, 0);

        // ---------------- reset asserted mid-WRITE
        drive(1, 0, 3'd4, 8'h70, 1); step(); chk("rs_load", 2'd0, 0, 8'h00, 1, 0);
        drive(0, 0, 3'd0, 8'h00, 1); step(); chk("rs_w0",   2'd0, 1, 8'h70, 1, 0);
        step();                             chk("rs_w1",   2'd1, 1, 8'h71, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_async", 2'd0, 0, 8'h00, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("rs_idle", 2'd0, 0, 8'h00, 0, 0);

        // ---------------- randomized run against the reference model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic          s, a, r;
            logic [2:0]    n;
            logic [AW-1:0] b;
            int            k;

            if (!m_active)          chk("rand", 2'd0, 0, 8'h00, 0, 0);
            else if (m_load)        chk("rand", 2'd0, 0, 8'h00, 1, 0);
            else if (m_q.size() > 0) chk("rand", m_q[0].sel, 1, m_q[0].addr, 1, 0);
            else                    chk("rand", 2'd0, 0, 8'h00, 1, 1);

            s = ($urandom_range(0, 3) == 0);
            a = ($urandom_range(0, 39) == 0);
            n = 3'($urandom_range(0, 7));
            b = AW'($urandom);
            r = ($urandom_range(0, 9) < 7);
            drive(s, a, n, b, r);

            if (a) begin
                m_active = 1'b0;
                m_load   = 1'b0;
                m_q.delete();
            end else if (!m_active) begin
                if (s) begin
                    m_active = 1'b1;
                    m_load   = 1'b1;
                    k = (n > 3'd4) ? 4 : int'(n);
                    for (int i = 0; i < k; i++) begin
                        wr_t w;
                        w.sel  = 2'(i);
                        w.addr = AW'(int'(b) + i);
                        m_q.push_back(w);
                    end
                end
            end else if (m_load) begin
                m_load = 1'b0;
            end else if (m_q.size() > 0) begin
                if (r) void'(m_q.pop_front());
            end else begin
                m_active = 1'b0;
            end

            step();
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
